// File: rtl/bit_serial_logic_seq_pkg.sv
// Shared definitions for the bit-serial logic sequencer: cell op encodings and FSM states.
package bit_serial_logic_seq_pkg;

  localparam logic [1:0] OP_AND    = 2'b00;
  localparam logic [1:0] OP_NOR    = 2'b01;
  localparam logic [1:0] OP_PASS_A = 2'b10;
  localparam logic [1:0] OP_ONE    = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/bit_serial_logic_seq_cell.sv
// Purely combinational 1-bit logic cell: AND / NOR / pass-A / const-1 selected by op.
module logic_bit_cell
  import bit_serial_logic_seq_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic [1:0] op_i,
  output logic       f_o
);

  always_comb begin
    f_o = 1'b0;
    unique case (op_i)
      OP_AND:    f_o = a_i & b_i;
      OP_NOR:    f_o = ~(a_i | b_i);
      OP_PASS_A: f_o = a_i;
      OP_ONE:    f_o = 1'b1;
      default:   f_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bit_serial_logic_seq.sv
// Bit-serial front/back end around logic_bit_cell: latches operands, feeds one bit pair per
// clock LSB first, collects the result. Optional zero flag: BIT_SERIAL_LOGIC_ZERO_FLAG_EN.
module bit_serial_logic_seq
  import bit_serial_logic_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cell_f;
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  logic_bit_cell u_cell (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .op_i (op_q),
    .f_o  (cell_f)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          op_d    = op;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        acc_d = {cell_f, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        // Last bit edge: publish the accumulator including the bit shifted in on this edge.
        if (cnt_q == CntW'(WIDTH - 1)) begin
          cnt_d    = '0;
          result_d = acc_d;
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
          zero_d   = (acc_d == '0);
`endif
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign result = result_q;
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
  assign zero   = zero_q;
`endif

endmodule

// File: tb/tb_bit_serial_logic_seq.sv
// Self-checking bench for bit_serial_logic_seq (WIDTH=8): vector table, back-to-back,
// mid-operation reset and random operations against a word-level model.
module tb_bit_serial_logic_seq;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
  logic         zero;
`endif

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  bit_serial_logic_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
    .zero   (zero),
`endif
    .result (result)
  );

  always #5 clk = ~clk;

  // Word-level reference: the op applied to every bit position at once.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (o)
      2'b00:   return a & b;
      2'b01:   return ~(a | b);
      2'b10:   return a;
      default: return '1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic scramble();
    op   = 2'($urandom);
    a_in = W'($urandom);
    b_in = W'($urandom);
  endtask

  // One full operation with start re-asserted mid-SHIFT (must be ignored).
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string tag);
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    chk({tag, " busy@E0"}, busy, 1);
    chk({tag, " done@E0"}, done, 0);
    for (int i = 1; i < W; i++) begin
      if (i == 2) start = 1'b1;
      if (i == 5) start = 1'b0;
      @(posedge clk); #1;
      scramble();
      chk({tag, " busy mid"}, busy, 1);
      chk({tag, " done mid"}, done, 0);
    end
    @(posedge clk); #1;
    chk({tag, " done@E0+W"}, done, 1);
    chk({tag, " busy@E0+W"}, busy, 0);
    chk({tag, " result"}, result, exp);
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
    chk({tag, " zero"}, zero, (exp == '0));
`endif
    @(posedge clk); #1;
    chk({tag, " done drop"}, done, 0);
    chk({tag, " result held"}, result, exp);
  endtask

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{op: 2'b00, a: 8'hCA, b: 8'h0F, exp: 8'h0A};
    vecs[1] = '{op: 2'b01, a: 8'hCA, b: 8'h0F, exp: 8'h30};
    vecs[2] = '{op: 2'b10, a: 8'hCA, b: 8'h0F, exp: 8'hCA};
    vecs[3] = '{op: 2'b11, a: 8'hCA, b: 8'h0F, exp: 8'hFF};
    vecs[4] = '{op: 2'b00, a: 8'hF0, b: 8'h0F, exp: 8'h00};
    vecs[5] = '{op: 2'b11, a: 8'hF0, b: 8'h0F, exp: 8'hFF};

    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", result, 0);
`ifdef BIT_SERIAL_LOGIC_ZERO_FLAG_EN
    chk("reset zero", zero, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Start held high: operations every W+2 cycles, inputs disturbed mid-SHIFT.
    @(negedge clk);
    op = 2'b00; a_in = 8'hFF; b_in = 8'h55; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3) scramble();
      if (c == 6) begin
        op = 2'b00; a_in = 8'hFF; b_in = 8'h55;
      end
      @(posedge clk); #1;
      chk($sformatf("b2b busy c%0d", c), busy, ((c % 10) < 8));
      chk($sformatf("b2b done c%0d", c), done, ((c % 10) == 8));
      if ((c % 10) == 8) chk($sformatf("b2b result c%0d", c), result, 8'h55);
    end
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("b2b drained result", result, 8'h55);

    // Reset during bit 4 of a pass-A operation.
    @(negedge clk);
    op = 2'b10; a_in = 8'hA5; b_in = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst result", result, 0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("midrst no done", done, 0);
    end
    run_op(2'b10, 8'hA5, 8'h3C, 8'hA5, "post-rst");

    // Random operations against the word-level model.
    for (int r = 0; r < 20; r++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(3, 0));
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
